spi_fnd_frame_tx: RTL and testbench



---
 rtl/spi_fnd_pkg.sv | 21 ++
 rtl/spi_fnd_frame_tx_shifter.sv | 62 ++++++
 rtl/spi_fnd_frame_tx.sv | 166 ++++++++++++++++
 tb/tb_spi_fnd_frame_tx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_fnd_pkg.sv
// rtl/spi_fnd_pkg.sv - shared types and constants for the FND SPI frame transmitter
package spi_fnd_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SETUP    = 3'd2,
        SHIFT_HI = 3'd3,
        SHIFT_LO = 3'd4,
        HOLD     = 3'd5,
        GAP      = 3'd6
    } frame_state_t;

    localparam logic [13:0] FND_MAX_VALUE  = 14'd9999;
    localparam int          FND_BYTE_SCALE = 100;

    function automatic logic [13:0] fnd_clamp(input logic [13:0] v);
        return (v > FND_MAX_VALUE) ? FND_MAX_VALUE : v;
    endfunction

endpackage

// File: rtl/spi_fnd_frame_tx_shifter.sv
// rtl/spi_fnd_frame_tx_shifter.sv - mode-0 byte shifter: SCLK low then high per bit, MSB first
module spi_tx_shifter #(
    parameter int CLK_DIV = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_go,
    input  logic [7:0] i_byte,
    output logic       o_sclk,
    output logic       o_mosi,
    output logic       o_byte_done
);
    localparam int                 DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic             r_active;
    logic             r_phase;
    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_bit;
    logic [7:0]       r_sr;
    logic             w_half_end;
    logic             w_byte_end;

    assign w_half_end  = (r_div == DIV_LAST);
    assign w_byte_end  = r_active & r_phase & w_half_end & (r_bit == 3'd0);
    assign o_byte_done = w_byte_end;
    assign o_sclk      = r_active & r_phase;
    assign o_mosi      = r_sr[7];

    // A reload on the final high cycle lets the next byte start on the same falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active <= 1'b0;
            r_phase  <= 1'b0;
            r_div    <= '0;
            r_bit    <= 3'd0;
            r_sr     <= 8'd0;
        end else if (i_go && (!r_active || w_byte_end)) begin
            r_active <= 1'b1;
            r_phase  <= 1'b0;
            r_div    <= '0;
            r_bit    <= 3'd7;
            r_sr     <= i_byte;
        end else if (r_active) begin
            if (w_half_end) begin
                r_div   <= '0;
                r_phase <= ~r_phase;
                if (r_phase) begin
                    if (r_bit == 3'd0) begin
                        r_active <= 1'b0;
                    end else begin
                        r_bit <= r_bit - 3'd1;
                        r_sr  <= {r_sr[6:0], 1'b0};
                    end
                end
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/spi_fnd_frame_tx.sv
// rtl/spi_fnd_frame_tx.sv - frame FSM sending value/100 and value%100 in one SS_N-low frame
module spi_fnd_frame_tx
    import spi_fnd_pkg::*;
#(
    parameter int CLK_DIV    = 50,
    parameter int GAP_CYCLES = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [13:0] value,
    output logic        busy,
    output logic        done,
    output logic        o_SCLK,
    output logic        o_MOSI,
    output logic        o_SS_N
);
    localparam int               CNT_MAX  = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int               CNT_W    = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    frame_state_t     r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [13:0]      r_work;
    logic [13:0]      r_pend;
    logic             r_pend_vld;
    logic [7:0]       r_hi;
    logic [7:0]       r_lo;
    logic [7:0]       w_hi;
    logic [7:0]       w_lo;
    logic             w_go;
    logic [7:0]       w_go_byte;
    logic             w_sclk;
    logic             w_shift_mosi;
    logic             w_byte_done;
    logic             w_gap_end;
    logic             w_frame_low;
    logic             w_mosi;

    assign w_hi = 8'(r_work / 14'(FND_BYTE_SCALE));
    assign w_lo = 8'(r_work % 14'(FND_BYTE_SCALE));

    spi_tx_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk         (clk),
        .reset       (reset),
        .i_go        (w_go),
        .i_byte      (w_go_byte),
        .o_sclk      (w_sclk),
        .o_mosi      (w_shift_mosi),
        .o_byte_done (w_byte_done)
    );

    assign w_gap_end   = (r_state == GAP) && (r_cnt == GAP_LAST);
    assign w_frame_low = (r_state == SETUP) || (r_state == SHIFT_HI) ||
                         (r_state == SHIFT_LO) || (r_state == HOLD);

    always_comb begin
        w_go      = 1'b0;
        w_go_byte = r_hi;
        w_mosi    = 1'b0;
        if (r_state == SETUP && r_cnt == DIV_LAST) begin
            w_go = 1'b1;
        end
        if (r_state == SHIFT_HI && w_byte_done) begin
            w_go      = 1'b1;
            w_go_byte = r_lo;
        end
        case (r_state)
            LOAD:                     w_mosi = w_hi[7];
            SETUP:                    w_mosi = r_hi[7];
            SHIFT_HI, SHIFT_LO, HOLD: w_mosi = w_shift_mosi;
            default:                  w_mosi = 1'b0;
        endcase
    end

    // The pending write comes first so a start on the GAP->LOAD cycle re-arms the slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_work     <= 14'd0;
            r_pend     <= 14'd0;
            r_pend_vld <= 1'b0;
            r_hi       <= 8'd0;
            r_lo       <= 8'd0;
        end else begin
            if (start && r_state != IDLE) begin
                r_pend     <= fnd_clamp(value);
                r_pend_vld <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_work  <= fnd_clamp(value);
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_hi    <= w_hi;
                    r_lo    <= w_lo;
                    r_cnt   <= '0;
                    r_state <= SETUP;
                end
                SETUP: begin
                    if (r_cnt == DIV_LAST) begin
                        r_cnt   <= '0;
                        r_state <= SHIFT_HI;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                SHIFT_HI: begin
                    if (w_byte_done) r_state <= SHIFT_LO;
                end
                SHIFT_LO: begin
                    if (w_byte_done) begin
                        r_cnt   <= '0;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (r_cnt == DIV_LAST) begin
                        r_cnt   <= '0;
                        r_state <= GAP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (w_gap_end) begin
                        r_cnt <= '0;
                        if (r_pend_vld) begin
                            r_work  <= r_pend;
                            r_state <= LOAD;
                            if (!start) r_pend_vld <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Every pin is registered, so the whole frame trails the FSM by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_SS_N <= 1'b1;
            o_SCLK <= 1'b0;
            o_MOSI <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            o_SS_N <= ~w_frame_low;
            o_SCLK <= w_sclk;
            o_MOSI <= w_mosi;
            busy   <= (r_state != IDLE);
            done   <= w_gap_end;
        end
    end

endmodule

// File: tb/tb_spi_fnd_frame_tx.sv
// tb/tb_spi_fnd_frame_tx.sv - self-checking bench: vector table, random values, coalescing, back-to-back, reset
module tb_spi_fnd_frame_tx;
    localparam int CLK_DIV    = 50;
    localparam int GAP_CYCLES = 200;
    localparam int LOW_CYC    = 34 * CLK_DIV;
    localparam int LATENCY    = 1 + 34 * CLK_DIV + GAP_CYCLES;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [13:0] value = 14'd0;
    logic        busy, done, o_SCLK, o_MOSI, o_SS_N;

    spi_fnd_frame_tx #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .value  (value),
        .busy   (busy),
        .done   (done),
        .o_SCLK (o_SCLK),
        .o_MOSI (o_MOSI),
        .o_SS_N (o_SS_N)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          low_cyc;
        int          fall_cyc;
        int          rise_cyc;
        int          glitch;
    } frame_t;

    typedef struct {
        logic [13:0] v;
        logic [7:0]  hi;
        logic [7:0]  lo;
    } vec_t;

    int     n_vec = 0;
    int     n_err = 0;
    frame_t frames[$];
    int     dones[$];
    frame_t cur;
    int     ncyc = 0;
    int     t_start = 0;
    int     t_busy_rise = -1;
    int     t_busy_fall = -1;
    int     n_busy_fall = 0;
    int     done_wide = 0;
    int     sclk_idle_err = 0;
    logic   prev_ssn = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0, prev_done = 1'b0, prev_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    function automatic int model_clamp(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    // Frame capture at the falling clock edge, away from where the DUT updates.
    always @(negedge clk) begin
        ncyc++;
        if (reset) begin
            cur.nbits = 0;
            cur.bits  = 16'd0;
            prev_ssn  = 1'b1;
            prev_sclk = 1'b0;
            prev_mosi = 1'b0;
            prev_done = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (prev_ssn && !o_SS_N) begin
                cur.bits     = 16'd0;
                cur.nbits    = 0;
                cur.low_cyc  = 0;
                cur.glitch   = 0;
                cur.fall_cyc = ncyc;
            end
            if (!o_SS_N) begin
                cur.low_cyc++;
                if (o_SCLK && !prev_sclk) begin
                    cur.bits = {cur.bits[14:0], o_MOSI};
                    cur.nbits++;
                end
                if (!prev_ssn && o_MOSI !== prev_mosi && !(prev_sclk && !o_SCLK)) cur.glitch++;
            end else if (o_SCLK) begin
                sclk_idle_err++;
            end
            if (!prev_ssn && o_SS_N) begin
                cur.rise_cyc = ncyc;
                frames.push_back(cur);
            end
            if (done) dones.push_back(ncyc);
            if (done && prev_done) done_wide++;
            if (busy && !prev_busy) t_busy_rise = ncyc;
            if (!busy && prev_busy) begin
                t_busy_fall = ncyc;
                n_busy_fall++;
            end
            prev_ssn  = o_SS_N;
            prev_sclk = o_SCLK;
            prev_mosi = o_MOSI;
            prev_done = done;
            prev_busy = busy;
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 4 * LATENCY && busy !== 1'b0; i++) @(posedge clk);
        if (busy !== 1'b0) check("idle_timeout", busy, 0);
    endtask

    task automatic pulse_start(input logic [13:0] v);
        @(posedge clk);
        #1 start = 1'b1;
        value   = v;
        t_start = ncyc + 1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_frame(input logic [13:0] v, input logic [7:0] ehi, input logic [7:0] elo, input string tag);
        frame_t f;
        int     st;
        wait_idle();
        frames.delete();
        dones.delete();
        pulse_start(v);
        st = t_start;
        for (int i = 0; i < LATENCY + 100 && (frames.size() == 0 || dones.size() == 0); i++) @(posedge clk);
        if (frames.size() == 0 || dones.size() == 0) begin
            check({tag, "_timeout"}, 0, 1);
            return;
        end
        repeat (3) @(posedge clk);
        f = frames[0];
        check({tag, "_hi"}, f.bits[15:8], ehi);
        check({tag, "_lo"}, f.bits[7:0], elo);
        check({tag, "_nbits"}, f.nbits, 16);
        check({tag, "_ssn_low"}, f.low_cyc, LOW_CYC);
        check({tag, "_mosi_stable"}, f.glitch, 0);
        check({tag, "_slave_value"}, int'(f.bits[15:8]) * 100 + int'(f.bits[7:0]), model_clamp(int'(v)));
        check({tag, "_latency"}, dones[0] - st - 1, LATENCY);
        check({tag, "_busy_rise"}, t_busy_rise - st, 2);
        check({tag, "_ssn_fall"}, f.fall_cyc - st, 3);
        check({tag, "_busy_fall"}, t_busy_fall - dones[0], 1);
        check({tag, "_done_count"}, dones.size(), 1);
    endtask

    initial begin
        vec_t        tbl[8];
        logic [13:0] rv;
        int          c, n0, g;
        tbl[0] = '{14'd1234,  8'h0C, 8'h22};
        tbl[1] = '{14'd12000, 8'h63, 8'h63};
        tbl[2] = '{14'd0,     8'h00, 8'h00};
        tbl[3] = '{14'd9999,  8'h63, 8'h63};
        tbl[4] = '{14'd10000, 8'h63, 8'h63};
        tbl[5] = '{14'd16383, 8'h63, 8'h63};
        tbl[6] = '{14'd100,   8'h01, 8'h00};
        tbl[7] = '{14'd5050,  8'h32, 8'h32};

        #1 reset = 1'b1;
        #2;
        check("rst_ssn", o_SS_N, 1);
        check("rst_sclk", o_SCLK, 0);
        check("rst_mosi", o_MOSI, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 8; i++) run_frame(tbl[i].v, tbl[i].hi, tbl[i].lo, $sformatf("tbl%0d", i));

        for (int i = 0; i < 5; i++) begin
            rv = 14'($urandom_range(0, 16383));
            c  = model_clamp(int'(rv));
            run_frame(rv, 8'(c / 100), 8'(c % 100), $sformatf("rnd%0d", i));
        end

        // Coalescing: only the newest of the in-flight requests survives.
        wait_idle();
        frames.delete();
        dones.delete();
        n0 = n_busy_fall;
        pulse_start(14'd5678);
        repeat (400) @(posedge clk);
        pulse_start(14'd1111);
        repeat (600) @(posedge clk);
        pulse_start(14'd2222);
        for (int i = 0; i < 2 * LATENCY && dones.size() < 2; i++) @(posedge clk);
        repeat (300) @(posedge clk);
        check("coal_frames", frames.size(), 2);
        check("coal_dones", dones.size(), 2);
        check("coal_busy_idle", busy, 0);
        check("coal_busy_falls", n_busy_fall - n0, 1);
        if (frames.size() == 2 && dones.size() == 2) begin
            check("coal_f0", int'(frames[0].bits[15:8]) * 100 + int'(frames[0].bits[7:0]), 5678);
            check("coal_f1", int'(frames[1].bits[15:8]) * 100 + int'(frames[1].bits[7:0]), 2222);
            check("coal_period", dones[1] - dones[0], LATENCY);
        end

        // start held high: every frame re-arms the pending slot.
        wait_idle();
        frames.delete();
        dones.delete();
        @(posedge clk);
        #1 start = 1'b1;
        value = 14'd42;
        for (int i = 0; i < 3 * LATENCY && dones.size() < 2; i++) @(posedge clk);
        #1 start = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk);
        check("held_frames", frames.size(), 4);
        check("held_dones", dones.size(), 4);
        for (int i = 0; i < frames.size(); i++) begin
            check($sformatf("held_val%0d", i), int'(frames[i].bits[15:8]) * 100 + int'(frames[i].bits[7:0]), 42);
            check($sformatf("held_nbits%0d", i), frames[i].nbits, 16);
            check($sformatf("held_low%0d", i), frames[i].low_cyc, LOW_CYC);
            if (i > 0) begin
                g = frames[i].fall_cyc - frames[i-1].rise_cyc;
                check($sformatf("held_gap%0d_in_range", i), (g >= GAP_CYCLES && g <= GAP_CYCLES + 1), 1);
                if (i < dones.size()) check($sformatf("held_period%0d", i), dones[i] - dones[i-1], LATENCY);
            end
        end

        // Reset in the middle of SHIFT_LO bit 3 (13th bit high phase).
        wait_idle();
        frames.delete();
        dones.delete();
        pulse_start(14'd5678);
        for (int i = 0; i < LATENCY && !(cur.nbits == 13 && o_SS_N == 1'b0); i++) @(posedge clk);
        check("mid_reset_reached_bit", cur.nbits, 13);
        check("mid_reset_sclk_high", o_SCLK, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_reset_ssn", o_SS_N, 1);
        check("mid_reset_sclk", o_SCLK, 0);
        check("mid_reset_mosi", o_MOSI, 0);
        check("mid_reset_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        run_frame(14'd77, 8'h00, 8'h4D, "post_reset");

        check("done_single_cycle", done_wide, 0);
        check("sclk_idle_low", sclk_idle_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
